// File: rtl/frogger_mem_arb_pkg.sv
// frogger_mem_arb_pkg: shared constants and types for the frogger RAM arbiter.
//   ADDR_W_DEFAULT / DATA_W_DEFAULT : default RAM geometry (4 x 32-bit)
//   resp_state_t                    : read-response state (IDLE, RESP0, RESP1)
//   master_t                        : master index (MST0 = Nios II, MST1 = sprite engine)
package frogger_mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 2;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {IDLE, RESP0, RESP1} resp_state_t;

    typedef enum logic {MST0 = 1'b0, MST1 = 1'b1} master_t;

endpackage

// File: rtl/frogger_mem_arb_sel.sv
// frogger_mem_arb_sel: combinational grant selection between two masters.
//   req0, req1 : request from m0 / m1 (already masked by reset)
//   last_grant : master granted most recently
//   grant      : one-hot grant, bit 0 = m0, bit 1 = m1 (zero when nobody requests)
// Macro FROGGER_MEM_ARB_RR_EN selects round-robin; otherwise m0 has fixed priority.
module frogger_mem_arb_sel
    import frogger_mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  master_t    last_grant,
    output logic [1:0] grant
);

`ifdef FROGGER_MEM_ARB_RR_EN
    // On a tie the master that did not win last time takes the slot.
    assign grant[0] = req0 & (~req1 | (last_grant == MST1));
    assign grant[1] = req1 & (~req0 | (last_grant == MST0));
`else
    logic unused_last_grant;

    assign unused_last_grant = last_grant;
    assign grant[0]          = req0;
    assign grant[1]          = req1 & ~req0;
`endif

endmodule

// File: rtl/frogger_mem_arbiter.sv
// frogger_mem_arbiter: shares a single-port 4 x 32-bit RAM between the Nios II
// data master (m0) and the sprite engine (m1), one access per clock, reads
// answered with fixed one-cycle latency to the issuing master.
//   clk, reset                 : clock, asynchronous active-high reset
//   m0_* / m1_*                : Avalon-MM slave ports facing the two masters
//   mem_*                      : RAM slave port (mem_readdata valid the cycle after address)
// Macro FROGGER_MEM_ARB_RR_EN selects round-robin arbitration (default: m0 fixed priority).
module frogger_mem_arbiter
    import frogger_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic              req0;
    logic              req1;
    logic [1:0]        grant;
    resp_state_t       state_q;
    resp_state_t       state_d;
    master_t           last_grant_q;
    master_t           last_grant_d;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q;
    logic [DATA_W-1:0] m1_rdata_d;

    // Masking requests with reset keeps the RAM quiet and no tag is set while reset is high.
    assign req0 = ~reset & (m0_read | m0_write);
    assign req1 = ~reset & (m1_read | m1_write);

    frogger_mem_arb_sel u_sel (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // A command with both read and write high is a write, so it never opens a response.
    always_comb begin
        state_d      = (grant[0] & m0_read & ~m0_write) ? RESP0 :
                       (grant[1] & m1_read & ~m1_write) ? RESP1 : IDLE;
        last_grant_d = grant[1] ? MST1 : grant[0] ? MST0 : last_grant_q;
        m0_rdata_d   = (state_q == RESP0) ? mem_readdata : m0_rdata_q;
        m1_rdata_d   = (state_q == RESP1) ? mem_readdata : m1_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= MST1;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign m0_waitrequest   = reset | (req0 & ~grant[0]);
    assign m1_waitrequest   = reset | (req1 & ~grant[1]);
    assign m0_readdatavalid = (state_q == RESP0);
    assign m1_readdatavalid = (state_q == RESP1);
    // The response cycle forwards the RAM word; otherwise the last captured word is held.
    assign m0_readdata      = m0_rdata_d;
    assign m1_readdata      = m1_rdata_d;

    assign mem_address      = grant[1] ? m1_address    : m0_address;
    assign mem_byteenable   = grant[1] ? m1_byteenable : m0_byteenable;
    assign mem_writedata    = grant[1] ? m1_writedata  : m0_writedata;
    assign mem_chipselect   = |grant;
    assign mem_write        = grant[1] ? m1_write : (grant[0] & m0_write);
    assign mem_clken        = ~reset;

endmodule
